psdsumsq: RTL

PSDSUMSQ -- requirements
Module: psdsumsq

---
 rtl/psdsumsq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/psdsumsq.sv
// Sum-of-squares front end for the PSD magnitude path: computes a*a + b*b with
// one shared shift-add multiplier and hands the result to the square-root stage.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SQA   | 16 shift-add iterations of |a|*|a|
// SQB   | 16 shift-add iterations of |b|*|b| into the same accumulator
// HOLD  | result ready, waiting for the square-root stage to be idle
// DONE  | one-cycle xvalid pulse, then back to IDLE
module psdsumsq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ready,
  output logic        busy,
  output logic [31:0] xout,
  output logic        xvalid
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQA  = 3'd1,
    SQB  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [15:0] mplier_q, mplier_d;
  logic [15:0] opb_q, opb_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] xout_q, xout_d;
  logic        xvalid_q, xvalid_d;

  logic [15:0] a_abs, b_abs;
  logic [31:0] acc_step;

  // Magnitude of -32768 wraps to 16'h8000, which is exactly 32768 unsigned.
  assign a_abs = a[15] ? (~a + 16'd1) : a;
  assign b_abs = b[15] ? (~b + 16'd1) : b;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    xout_d   = xout_q;
    xvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {16'd0, a_abs};
          mplier_d = a_abs;
          opb_d    = b_abs;
          acc_d    = 32'd0;
          cnt_d    = 4'd0;
          state_d  = SQA;
        end
      end
      SQA, SQB: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[15:1]};
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          if (state_q == SQA) begin
            mcand_d  = {16'd0, opb_q};
            mplier_d = opb_q;
            state_d  = SQB;
          end else begin
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (ready) begin
          xout_d   = acc_q;
          xvalid_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 16'd0;
      opb_q    <= 16'd0;
      cnt_q    <= 4'd0;
      xout_q   <= 32'd0;
      xvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      xout_q   <= xout_d;
      xvalid_q <= xvalid_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign xout   = xout_q;
  assign xvalid = xvalid_q;

endmodule
